// File: rtl/u21_pkg.sv
// u21_pkg: shared definitions for the u21 wiring sequencer.
//   W_O/W_I/W_A/W_B : legal wiring codes (bit 2 clear)
//   WW, NPIN, FW    : code width, pins per cell, truth-table width
//   state_t         : sequencer state encoding
package u21_pkg;

  localparam logic [2:0] W_O = 3'd0;
  localparam logic [2:0] W_I = 3'd1;
  localparam logic [2:0] W_A = 3'd2;
  localparam logic [2:0] W_B = 3'd3;

  localparam int WW   = 3;
  localparam int NPIN = 4;
  localparam int FW   = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/u21_settle_timer.sv
// u21_settle_timer: loadable down-counter that paces reference sampling.
//   clk, rst_n : clock, async active-low reset (count clears to 0)
//   load       : reload with LATENCY-1 (has priority over dec)
//   dec        : count down by one, saturating at zero
//   zero       : count is zero, i.e. the reference output has settled
module u21_settle_timer #(
  parameter int LATENCY = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(LATENCY - 1);
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/u21_wiring_seq.sv
// u21_wiring_seq: walks the u21_ref query port over every pin for one truth
// table and returns the packed wiring word.
//   clk, rst_n          : clock, async active-low reset
//   req_valid/ready/func: job request (accepted only in IDLE)
//   ref_func, ref_pin   : query drive to u21_ref (func held for the whole job)
//   ref_wiring          : registered code returned by u21_ref
//   rsp_valid/ready     : response handshake
//   rsp_wiring          : code for pin p at [WW*p +: WW]
//   rsp_func, rsp_err   : echoed func; any captured code had bit 2 set
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for a request, req_ready high
// ST_SETTLE | timer running for ref_pin; sample when it reaches zero
// ST_DONE   | response held on rsp_* until the consumer takes it
module u21_wiring_seq #(
  parameter int LATENCY = 2,
  parameter int NPIN    = 4,
  parameter int WW      = 3,
  localparam int PW     = (NPIN > 1) ? $clog2(NPIN) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [u21_pkg::FW-1:0] req_func,
  output logic [u21_pkg::FW-1:0] ref_func,
  output logic [PW-1:0]          ref_pin,
  input  logic [WW-1:0]          ref_wiring,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [NPIN*WW-1:0]     rsp_wiring,
  output logic [u21_pkg::FW-1:0] rsp_func,
  output logic                   rsp_err
);

  import u21_pkg::*;

  state_t              state;
  logic [NPIN*WW-1:0]  acc;
  logic [NPIN*WW-1:0]  acc_nxt;
  logic                err;
  logic                err_nxt;
  logic                last_pin;
  logic                tmr_zero;
  logic                tmr_load;
  logic                tmr_dec;

  assign last_pin = (ref_pin == PW'(NPIN - 1));

  // Accumulator with the current sample merged in, so the final pin's code
  // lands in the response in the same edge it is captured.
  always_comb begin
    acc_nxt = acc;
    acc_nxt[int'(ref_pin)*WW +: WW] = ref_wiring;
    err_nxt = err | ref_wiring[WW-1];
  end

  assign tmr_load = ((state == ST_IDLE) && req_valid && req_ready) ||
                    ((state == ST_SETTLE) && tmr_zero && !last_pin);
  assign tmr_dec  = (state == ST_SETTLE) && !tmr_zero;

  u21_settle_timer #(.LATENCY(LATENCY)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (tmr_load),
    .dec   (tmr_dec),
    .zero  (tmr_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      req_ready  <= 1'b1;
      ref_func   <= '0;
      ref_pin    <= '0;
      acc        <= '0;
      err        <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_wiring <= '0;
      rsp_func   <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            ref_func  <= req_func;
            ref_pin   <= '0;
            acc       <= '0;
            err       <= 1'b0;
            req_ready <= 1'b0;
            state     <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (tmr_zero) begin
            acc <= acc_nxt;
            err <= err_nxt;
            if (last_pin) begin
              rsp_wiring <= acc_nxt;
              rsp_func   <= ref_func;
              rsp_err    <= err_nxt;
              rsp_valid  <= 1'b1;
              state      <= ST_DONE;
            end else begin
              ref_pin <= ref_pin + PW'(1);
            end
          end
        end
        ST_DONE: begin
          // Retirement and the next acceptance never share a cycle.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_u21_wiring_seq.sv
// tb_u21_wiring_seq: scoreboard bench for u21_wiring_seq with a behavioural
// u21_ref stand-in (registered table lookup, optional pin-2 fault injection).
module tb_u21_wiring_seq;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_func = 4'd0;
  logic [3:0]  ref_func;
  logic [1:0]  ref_pin;
  logic [2:0]  ref_wiring;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [11:0] rsp_wiring;
  logic [3:0]  rsp_func;
  logic        rsp_err;
  logic        inject = 1'b0;

  logic        req_valid3 = 1'b0;
  logic        req_ready3;
  logic [3:0]  req_func3 = 4'd0;
  logic [3:0]  ref_func3;
  logic [1:0]  ref_pin3;
  logic [2:0]  ref_wiring3;
  logic        rsp_valid3;
  logic        rsp_ready3 = 1'b1;
  logic [11:0] rsp_wiring3;
  logic [3:0]  rsp_func3;
  logic        rsp_err3;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    logic [3:0]  func;
    logic [11:0] wiring;
    logic        err;
    int          e0;
  } exp_t;
  exp_t q[$];

  logic       job_active = 1'b0;
  int         cur_e0 = 0;
  logic [3:0] cur_func = 4'd0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  u21_wiring_seq #(.LATENCY(LAT)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_func(req_func),
    .ref_func(ref_func), .ref_pin(ref_pin), .ref_wiring(ref_wiring),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_wiring(rsp_wiring), .rsp_func(rsp_func), .rsp_err(rsp_err)
  );

  u21_wiring_seq #(.LATENCY(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid3), .req_ready(req_ready3), .req_func(req_func3),
    .ref_func(ref_func3), .ref_pin(ref_pin3), .ref_wiring(ref_wiring3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
    .rsp_wiring(rsp_wiring3), .rsp_func(rsp_func3), .rsp_err(rsp_err3)
  );

  // Hand-resolved wiring words for the truth tables exercised here.
  function automatic logic [11:0] ref_word(input logic [3:0] f);
    case (f)
      4'b0000: return 12'h000;
      4'b0001: return 12'h4D0;
      4'b0101: return 12'h400;
      4'b1000: return 12'h691;
      4'b1111: return 12'h200;
      default: return 12'h000;
    endcase
  endfunction

  function automatic logic [2:0] ref_code(input logic [3:0] f, input logic [1:0] p,
                                          input logic inj);
    logic [11:0] w;
    w = ref_word(f);
    if (inj && p == 2'd2) return 3'd5;
    return w[int'(p)*3 +: 3];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_wiring  <= 3'd0;
      ref_wiring3 <= 3'd0;
    end else begin
      ref_wiring  <= ref_code(ref_func, ref_pin, inject);
      ref_wiring3 <= ref_code(ref_func3, ref_pin3, 1'b0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Request monitor pushes expectations; response monitor pops and compares.
  initial begin : monitor
    logic rv_prev;
    exp_t e;
    int k;
    rv_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rv_prev = 1'b0;
        job_active = 1'b0;
      end else begin
        if (job_active) begin
          k = cyc - cur_e0;
          if (k >= 0 && k < 4*LAT) begin
            chk("ref_pin_seq", 32'(ref_pin), 32'(k / LAT));
            chk("ref_func_hold", 32'(ref_func), 32'(cur_func));
          end
        end
        if (rsp_valid && !rv_prev) begin
          job_active = 1'b0;
          if (q.size() == 0) begin
            chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
          end else begin
            e = q.pop_front();
            chk("rsp_latency", 32'(cyc), 32'(e.e0 + 4*LAT));
            chk("rsp_wiring", 32'(rsp_wiring), 32'(e.wiring));
            chk("rsp_func", 32'(rsp_func), 32'(e.func));
            chk("rsp_err", 32'(rsp_err), 32'(e.err));
          end
        end
        if (req_valid && req_ready) begin
          e.func = req_func;
          e.wiring = 12'h000;
          e.err = 1'b0;
          for (int p = 0; p < 4; p++) begin
            e.wiring[p*3 +: 3] = ref_code(req_func, 2'(p), inject);
            e.err = e.err | e.wiring[p*3 + 2];
          end
          e.e0 = cyc + 1;
          q.push_back(e);
          job_active = 1'b1;
          cur_e0 = cyc + 1;
          cur_func = req_func;
        end
        rv_prev = rsp_valid;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves req_valid high; returns just after the accepting edge.
  task automatic send(input logic [3:0] f);
    int n;
    req_func = f;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("send_timeout", 32'(n), 32'd0);
    tick();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(q.size() == 0 && !job_active && req_ready && !rsp_valid) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("idle_timeout", 32'(n), 32'd0);
  endtask

  initial begin
    int n;
    // Reset values while reset is held.
    #22;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_wiring", 32'(rsp_wiring), 32'd0);
    chk("rst_rsp_func", 32'(rsp_func), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_ref_func", 32'(ref_func), 32'd0);
    chk("rst_ref_pin", 32'(ref_pin), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single job.
    send(4'b0001);
    req_valid = 1'b0;
    wait_idle();

    // Back-to-back sweep with req_valid held high.
    send(4'b0000);
    send(4'b0101);
    send(4'b1000);
    send(4'b1111);
    req_valid = 1'b0;
    wait_idle();

    // Backpressure: response must hold, a pending request must wait.
    rsp_ready = 1'b0;
    send(4'b0101);
    req_func = 4'b1000;
    n = 0;
    while (!rsp_valid && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("stall_timeout", 32'(n), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", 32'(rsp_valid), 32'd1);
      chk("stall_wiring", 32'(rsp_wiring), 32'h400);
      chk("stall_func", 32'(rsp_func), 32'h5);
      chk("stall_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    chk("retire_valid", 32'(rsp_valid), 32'd0);
    chk("retire_req_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    wait_idle();

    // Illegal code on pin 2 flags an error; next clean job clears it.
    inject = 1'b1;
    send(4'b0001);
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 50) begin
      tick();
      n++;
    end
    chk("err_flag", 32'(rsp_err), 32'd1);
    chk("err_wiring", 32'(rsp_wiring), 32'h550);
    wait_idle();
    inject = 1'b0;
    send(4'b1000);
    req_valid = 1'b0;
    wait_idle();
    chk("err_cleared", 32'(rsp_err), 32'd0);

    // Reset in the middle of a job.
    send(4'b1111);
    req_valid = 1'b0;
    n = 0;
    while (ref_pin != 2'd1 && n < 50) begin
      tick();
      n++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    q.delete();
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_rsp_wiring", 32'(rsp_wiring), 32'd0);
    chk("abort_rsp_func", 32'(rsp_func), 32'd0);
    chk("abort_rsp_err", 32'(rsp_err), 32'd0);
    chk("abort_ref_func", 32'(ref_func), 32'd0);
    chk("abort_ref_pin", 32'(ref_pin), 32'd0);
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    tick();
    tick();
    chk("abort_no_valid", 32'(rsp_valid), 32'd0);
    rst_n = 1'b1;
    tick();
    send(4'b1000);
    req_valid = 1'b0;
    wait_idle();

    // LATENCY=3 instance: pins sampled every third edge, result at E0+12.
    req_func3 = 4'b0001;
    req_valid3 = 1'b1;
    tick();
    req_valid3 = 1'b0;
    n = 0;
    while (n < 30) begin
      tick();
      n++;
      if (rsp_valid3) break;
      chk("lat3_ref_pin", 32'(ref_pin3), 32'(n / 3));
    end
    chk("lat3_latency", 32'(n), 32'd12);
    chk("lat3_wiring", 32'(rsp_wiring3), 32'h4D0);
    chk("lat3_err", 32'(rsp_err3), 32'd0);
    tick();
    chk("lat3_retire", 32'(rsp_valid3), 32'd0);

    if (q.size() != 0) chk("queue_leftover", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got time %0t expected finish earlier", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/u21_wiring_seq.md
Name: u21_wiring_seq

Overview:
- Sequencer that sits directly downstream of `u21_ref` and drives its query interface.
- For each accepted 4-bit truth table (`func[0]` = f(0,0) … `func[3]` = f(1,1)) it walks `pin` 0..3.
- At each pin it waits a fixed settle latency and captures the 3-bit wiring code.
- The four codes are packed into one 12-bit wiring word and delivered over a valid/ready response port to the cell-configuration logic.

Parameters:
- LATENCY, 2, rising edges between `ref_pin`/`ref_func` changing and `ref_wiring` being sampled (must be ≥1).
- NPIN, 4, pins per universal cell; `pin` width is clog2(NPIN).
- WW, 3, wiring code width; packed word is NPIN*WW bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request (IDLE only).
- req_func  in  4  truth table to resolve.
- ref_func  out  4  to `u21_ref.func`; held stable for the whole job.
- ref_pin  out  2  to `u21_ref.pin`.
- ref_wiring  in  3  from `u21_ref.wiring`.
- rsp_valid  out  1  packed result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_wiring  out  12  `rsp_wiring[3p+:3]` = code captured for pin p.
- rsp_func  out  4  echo of the resolved func.
- rsp_err  out  1  at least one captured code was outside {O=0, I=1, a=2, b=3}, i.e. had bit 2 set.

Behaviour:
- Reset: state IDLE; all registers zero.
  - Outputs: `req_ready`=1, `rsp_valid`=0, `rsp_wiring`=0, `rsp_func`=0, `rsp_err`=0, `ref_func`=0, `ref_pin`=0.
  - Reset asserted mid-job aborts the job immediately. No partial response is ever emitted.
- States: IDLE, SETTLE, DONE.
- IDLE:
  - `req_ready`=1.
  - Handshake is `req_valid & req_ready` at an edge. On it: latch `req_func` into `ref_func`; set `ref_pin`=0; clear the wiring accumulator and error flag; load the settle counter with LATENCY-1; go to SETTLE.
- SETTLE:
  - `req_ready`=0.
  - While the counter is nonzero, decrement it each edge.
  - When the counter is 0, sample `ref_wiring` into `acc[3*ref_pin+:3]` and OR `ref_wiring[2]` into err.
    - If `ref_pin` < 3: increment `ref_pin`, reload the counter, stay in SETTLE.
    - If `ref_pin` = 3: load `rsp_wiring`/`rsp_func`/`rsp_err` from the final accumulator (including this sample), assert `rsp_valid`, go to DONE. `ref_pin` stays 3.
- Timing: with the handshake at edge E0, pin p is sampled at edge E0+(p+1)*LATENCY. `rsp_valid` rises at E0+4*LATENCY (8 edges for the default).
- DONE:
  - `rsp_valid`=1. `rsp_wiring`, `rsp_func` and `rsp_err` are held stable until the handshake.
  - `rsp_valid & rsp_ready` at an edge: `rsp_valid`→0, go to IDLE; `req_ready`=1 from the next cycle.
  - No request is accepted in the same cycle as response retirement (max throughput: one job per 4*LATENCY+2 cycles).
- `rsp_ready` high before `rsp_valid` has no effect. `req_valid` outside IDLE is ignored; the request is not lost because `req_ready`=0.
- `ref_wiring` is a registered output of `u21_ref` and is treated as synchronous. No internal synchronizer.
- Response data registers are updated only at the SETTLE→DONE transition; otherwise they hold their previous values.

Decomposition:
- Shared package `u21_pkg`:
  - Code constants `W_O`=3'd0, `W_I`=3'd1, `W_A`=3'd2, `W_B`=3'd3.
  - Width constants WW=3, NPIN=4, FW=4.
  - Typedef for the state enum.
- One natural sub-module: `u21_settle_timer`, a loadable down-counter with a `zero` flag, parameterized by LATENCY.
- The FSM and accumulator stay in the top module. `u21_ref` is instantiated by the integrating level, not inside this block.

Test Plan:
- Bench connects a real `u21_ref`. `req_func`=4'b0001, `rsp_ready`=1 → `rsp_valid` at E0+8, `rsp_wiring`=12'h4D0 ({a,b,a,O}), `rsp_func`=1, `rsp_err`=0.
- Sweep `req_func`=0000, 0101, 1000, 1111 back-to-back with `req_valid` held high → `rsp_wiring`=12'h000, 12'h400, 12'h691, 12'h200 in order; `ref_pin` sequence 0,0,1,1,2,2,3,3 per job.
- `rsp_ready`=0 for 5 cycles after `rsp_valid` → outputs stable, `req_ready`=0 throughout; release → `rsp_valid` drops next edge, `req_ready`=1.
- Stub `ref_wiring` returns 3'd5 on pin 2 → `rsp_err`=1, `rsp_wiring[8:6]`=3'd5; the next job with clean codes → `rsp_err`=0.
- Assert `rst_n`=0 during SETTLE at pin 1 → all outputs zero asynchronously, no `rsp_valid`; a new request after release completes normally with correct wiring.
- LATENCY=3 build → pins sampled at E0+3, +6, +9, +12; `rsp_valid` at E0+12.
